// File: rtl/conv_pkg.sv
// Shared constants, lane state encoding and tap packing helpers for the
// conv MAC pool and the conv assignment FSM that feeds it.
package conv_pkg;

   localparam int NMULT = 8;                       // MAC lanes
   localparam int F     = 3;                       // kernel side
   localparam int W     = 24;                      // signed tap width
   localparam int IDXW  = 24;                      // conv index width
   localparam int NTAP  = F * F;                   // taps per job
   localparam int MB    = $clog2(NMULT);           // lane index width
   localparam int TCW   = $clog2(NTAP);            // tap counter width
   localparam int ACCW  = 2 * W + $clog2(NTAP);    // never overflows for NTAP taps

   typedef enum logic [1:0] {
      LANE_IDLE,
      LANE_RUN,
      LANE_HOLD
   } lane_state_e;

   // Tap t lives at bits [t*W +: W].
   typedef logic [NTAP*W-1:0] taps_t;

   function automatic logic signed [W-1:0] tap_get(input taps_t v, input int t);
      return v[t*W +: W];
   endfunction

   function automatic taps_t tap_put(input taps_t v, input int t, input logic [W-1:0] x);
      taps_t r;
      r = v;
      r[t*W +: W] = x;
      return r;
   endfunction

endpackage

// File: rtl/conv_mac_pool_if.sv
// Job request and result channels of the MAC pool. The master side is the
// job source / result sink; the pool itself is the slave.
interface conv_mac_pool_if;
   import conv_pkg::*;

   logic                   job_valid;
   logic                   job_ready;
   logic [MB-1:0]          job_lane;
   logic [IDXW-1:0]        job_idx;
   logic                   job_last;
   taps_t                  job_img;
   taps_t                  job_flt;

   logic                   res_valid;
   logic                   res_ready;
   logic signed [ACCW-1:0] res_data;
   logic [IDXW-1:0]        res_idx;
   logic [MB-1:0]          res_lane;

   modport master (
      output job_valid, job_lane, job_idx, job_last, job_img, job_flt, res_ready,
      input  job_ready, res_valid, res_data, res_idx, res_lane
   );

   modport slave (
      input  job_valid, job_lane, job_idx, job_last, job_img, job_flt, res_ready,
      output job_ready, res_valid, res_data, res_idx, res_lane
   );

endinterface

// File: rtl/conv_mac_lane.sv
// One serial signed MAC lane: latches a job, consumes one tap per cycle for
// NTAP cycles, then holds its dot product until the arbiter drains it.
module conv_mac_lane
   import conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   start,
   input  taps_t                  img,
   input  taps_t                  flt,
   input  logic [IDXW-1:0]        idx,
   input  logic                   drain,
   output logic                   busy,
   output logic                   hold,
   output logic                   fin,      // last tap is consumed this cycle
   output logic signed [ACCW-1:0] acc,
   output logic signed [ACCW-1:0] acc_nxt,  // acc including the current tap
   output logic [IDXW-1:0]        idx_q
);

   lane_state_e          st;
   taps_t                img_q;
   taps_t                flt_q;
   logic [TCW-1:0]       cnt;
   logic signed [2*W-1:0] prod;

   // Taps are shifted down one slot per cycle, so the current tap is always
   // the bottom W bits and no variable indexing is needed.
   assign prod    = $signed(img_q[W-1:0]) * $signed(flt_q[W-1:0]);
   assign acc_nxt = acc + {{(ACCW-2*W){prod[2*W-1]}}, prod};
   assign busy    = (st != LANE_IDLE);
   assign hold    = (st == LANE_HOLD);
   assign fin     = (st == LANE_RUN) && (cnt == TCW'(NTAP-1));

   // Lane FSM: IDLE -> RUN on start, RUN -> HOLD after the last tap, HOLD -> IDLE on drain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st    <= LANE_IDLE;
         img_q <= '0;
         flt_q <= '0;
         cnt   <= '0;
         acc   <= '0;
         idx_q <= '0;
      end else if (!en) begin
         st    <= LANE_IDLE;
         img_q <= '0;
         flt_q <= '0;
         cnt   <= '0;
         acc   <= '0;
         idx_q <= '0;
      end else begin
         case (st)
            LANE_IDLE: if (start) begin
               st    <= LANE_RUN;
               img_q <= img;
               flt_q <= flt;
               idx_q <= idx;
               cnt   <= '0;
               acc   <= '0;
            end
            LANE_RUN: begin
               acc   <= acc_nxt;
               img_q <= img_q >> W;
               flt_q <= flt_q >> W;
               cnt   <= cnt + TCW'(1);
               if (fin) st <= LANE_HOLD;
            end
            LANE_HOLD: if (drain) st <= LANE_IDLE;
            default: st <= LANE_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/conv_mac_pool.sv
// MAC pool top: job acceptance, NMULT serial MAC lanes, round-robin result
// arbiter with a registered output stage, outstanding-job tracking and the
// partial/full done pulses back to the conv FSM.
module conv_mac_pool
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   conv_mac_pool_if.slave   bus,
   output logic [NMULT-1:0] lane_busy,
   output logic             conv_done_partial,
   output logic             conv_done_full
);

   localparam int OCW = MB + 1;

   logic                              accept, drain;
   logic [NMULT-1:0]                  start, drain_v, hold, fin;
   logic [NMULT-1:0][ACCW-1:0]        acc, acc_nxt;
   logic [NMULT-1:0][IDXW-1:0]        idx_q;

   logic [NMULT-1:0]                  cand;
   logic                              pick_vld;
   logic [MB-1:0]                     pick;
   logic [ACCW-1:0]                   sel_data;

   logic                              res_valid_q;
   logic [ACCW-1:0]                   res_data_q;
   logic [IDXW-1:0]                   res_idx_q;
   logic [MB-1:0]                     res_lane_q;
   logic [MB-1:0]                     rr_q;
   logic [OCW-1:0]                    outstanding;
   logic                              last_seen;

   // Busy is the registered lane state, so a lane drained this cycle can only
   // be re-targeted from the next cycle. rstn gating keeps the output low in reset.
   assign bus.job_ready = rstn && en && !last_seen
                       && (int'(bus.job_lane) < NMULT) && !lane_busy[bus.job_lane];
   assign accept        = bus.job_valid && bus.job_ready;
   assign drain         = res_valid_q && bus.res_ready;

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_idx   = res_idx_q;
   assign bus.res_lane  = res_lane_q;

   for (genvar g = 0; g < NMULT; g++) begin : g_lane
      assign start[g]   = accept && (bus.job_lane == MB'(g));
      assign drain_v[g] = drain && (res_lane_q == MB'(g));

      conv_mac_lane u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .en      (en),
         .start   (start[g]),
         .img     (bus.job_img),
         .flt     (bus.job_flt),
         .idx     (bus.job_idx),
         .drain   (drain_v[g]),
         .busy    (lane_busy[g]),
         .hold    (hold[g]),
         .fin     (fin[g]),
         .acc     (acc[g]),
         .acc_nxt (acc_nxt[g]),
         .idx_q   (idx_q[g])
      );
   end

   // Round-robin pick after the last granted lane. Lanes finishing this cycle
   // compete too, which gives the NTAP-cycle accept-to-result latency; the lane
   // already sitting in the output register is excluded.
   always_comb begin
      cand     = '0;
      pick_vld = 1'b0;
      pick     = '0;
      for (int i = 0; i < NMULT; i++)
         cand[i] = fin[i] || (hold[i] && !(res_valid_q && res_lane_q == MB'(i)));
      for (int k = 1; k <= NMULT; k++) begin
         if (!pick_vld && cand[(int'(rr_q) + k) % NMULT]) begin
            pick_vld = 1'b1;
            pick     = MB'((int'(rr_q) + k) % NMULT);
         end
      end
   end

   assign sel_data = fin[pick] ? acc_nxt[pick] : acc[pick];

   // Output stage: loads a new result whenever empty or being drained, else holds.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_idx_q   <= '0;
         res_lane_q  <= '0;
         rr_q        <= '0;
      end else if (!en) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_idx_q   <= '0;
         res_lane_q  <= '0;
         rr_q        <= '0;
      end else if (!res_valid_q || bus.res_ready) begin
         res_valid_q <= pick_vld;
         if (pick_vld) begin
            res_data_q <= sel_data;
            res_idx_q  <= idx_q[pick];
            res_lane_q <= pick;
            rr_q       <= pick;
         end
      end
   end

   // Outstanding count, layer-end latch and done pulses; a drain that empties
   // the pool with no concurrent accept ends either a batch or the layer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding       <= '0;
         last_seen         <= 1'b0;
         conv_done_partial <= 1'b0;
         conv_done_full    <= 1'b0;
      end else if (!en) begin
         outstanding       <= '0;
         last_seen         <= 1'b0;
         conv_done_partial <= 1'b0;
         conv_done_full    <= 1'b0;
      end else begin
         if (accept && !drain)      outstanding <= outstanding + OCW'(1);
         else if (drain && !accept) outstanding <= outstanding - OCW'(1);
         if (accept && bus.job_last) last_seen <= 1'b1;
         conv_done_partial <= drain && !accept && (outstanding == OCW'(1)) && !last_seen;
         conv_done_full    <= drain && !accept && (outstanding == OCW'(1)) &&  last_seen;
      end
   end

endmodule

// File: tb/tb_conv_mac_pool.sv
// Directed bench for conv_mac_pool: latency, signed math, arbitration under
// backpressure, busy-lane blocking, layer completion and enable abort.
module tb_conv_mac_pool;
   import conv_pkg::*;

   logic             clk = 1'b0;
   logic             rstn;
   logic             en;
   logic [NMULT-1:0] lane_busy;
   logic             conv_done_partial;
   logic             conv_done_full;

   int compared   = 0;
   int mismatched = 0;

   conv_mac_pool_if bus ();

   conv_mac_pool dut (
      .clk               (clk),
      .rstn              (rstn),
      .en                (en),
      .bus               (bus),
      .lane_busy         (lane_busy),
      .conv_done_partial (conv_done_partial),
      .conv_done_full    (conv_done_full)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Builds a tap vector: every tap = a + b*t.
   function automatic taps_t mk(input int a, input int b);
      taps_t v;
      v = '0;
      for (int t = 0; t < NTAP; t++) v = tap_put(v, t, W'(a + b * t));
      return v;
   endfunction

   // Offers one job from a negedge and returns 1ns after the accepting edge.
   task automatic drive_job(input int lane, input int idx, input bit last,
                            input taps_t img, input taps_t flt, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus.job_valid = 1'b1;
      bus.job_lane  = MB'(lane);
      bus.job_idx   = IDXW'(idx);
      bus.job_last  = last;
      bus.job_img   = img;
      bus.job_flt   = flt;
      for (int c = 0; c < 40 && !ok; c++) begin
         #1;
         if (bus.job_ready) begin
            ok = 1'b1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      #1;
      bus.job_valid = 1'b0;
      bus.job_last  = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0; en = 1'b1;
      bus.job_valid = 1'b0; bus.job_lane = '0; bus.job_idx = '0; bus.job_last = 1'b0;
      bus.job_img = '0; bus.job_flt = '0; bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      compared++; if (lane_busy !== '0) begin mismatched++; $display("FAIL reset_busy: got %h want 0", lane_busy); end
      compared++; if (bus.res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
      compared++; if (bus.res_data !== '0) begin mismatched++; $display("FAIL reset_res_data: got %0d want 0", bus.res_data); end
      compared++; if (bus.job_ready !== 1'b0) begin mismatched++; $display("FAIL reset_job_ready: got %b want 0", bus.job_ready); end
      compared++; if ({conv_done_partial, conv_done_full} !== 2'b00) begin mismatched++; $display("FAIL reset_done: got %b want 00", {conv_done_partial, conv_done_full}); end
      rstn = 1'b1;
      @(negedge clk); #1;
      compared++; if (bus.job_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_ready: got %b want 1", bus.job_ready); end
   endtask

   task automatic test_basic;
      bit ok; int lat;
      logic signed [ACCW-1:0] exp_d;
      bus.res_ready = 1'b1;
      drive_job(0, 5, 1'b0, mk(1, 0), mk(1, 1), ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL basic_accept: got timeout want accept"); end
      lat = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.res_valid) begin lat = k; break; end
      end
      exp_d = 45;
      compared++; if (lat != 9) begin mismatched++; $display("FAIL basic_latency: got %0d want 9", lat); end
      compared++; if (bus.res_data !== exp_d) begin mismatched++; $display("FAIL basic_data: got %0d want %0d", bus.res_data, exp_d); end
      compared++; if (bus.res_lane !== 3'd0 || bus.res_idx !== 24'd5) begin mismatched++; $display("FAIL basic_lane_idx: got %0d/%0d want 0/5", bus.res_lane, bus.res_idx); end
      @(negedge clk);
      compared++; if ({conv_done_partial, conv_done_full} !== 2'b10) begin mismatched++; $display("FAIL basic_partial: got %b want 10", {conv_done_partial, conv_done_full}); end
      compared++; if (lane_busy !== '0 || bus.res_valid !== 1'b0) begin mismatched++; $display("FAIL basic_idle: got busy %h valid %b want 0 0", lane_busy, bus.res_valid); end
      @(negedge clk);
      compared++; if (conv_done_partial !== 1'b0) begin mismatched++; $display("FAIL basic_pulse_width: got %b want 0", conv_done_partial); end
   endtask

   task automatic test_negative;
      bit ok; bit seen;
      logic signed [ACCW-1:0] exp_d;
      bus.res_ready = 1'b1;
      drive_job(1, 7, 1'b0, mk(-1, 0), mk(2, 0), ok);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = bus.res_valid;
      end
      exp_d = -18;
      compared++; if (!ok || !seen) begin mismatched++; $display("FAIL neg_result: got accept %b valid %b want 1 1", ok, seen); end
      compared++; if (bus.res_data !== exp_d) begin mismatched++; $display("FAIL neg_data: got %0d want %0d", bus.res_data, exp_d); end
      compared++; if (bus.res_idx !== 24'd7 || bus.res_lane !== 3'd1) begin mismatched++; $display("FAIL neg_idx_lane: got %0d/%0d want 7/1", bus.res_idx, bus.res_lane); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      bit ok0, ok1, ok2; int bad, pulses;
      logic signed [ACCW-1:0] exp_d;
      bus.res_ready = 1'b0;
      drive_job(0, 10, 1'b0, mk(1, 0), mk(1, 0), ok0);   //  9
      drive_job(1, 11, 1'b0, mk(2, 0), mk(3, 0), ok1);   // 54
      drive_job(2, 12, 1'b0, mk(0, 1), mk(-1, 0), ok2);  // -36
      compared++; if (!(ok0 && ok1 && ok2)) begin mismatched++; $display("FAIL b2b_accept: got %b%b%b want 111", ok0, ok1, ok2); end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.res_valid && (bus.res_lane !== 3'd0 || bus.res_data !== 52'sd9)) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL b2b_hold_stable: got %0d unstable cycles want 0", bad); end
      compared++; if (bus.res_valid !== 1'b1 || bus.res_lane !== 3'd0 || bus.res_idx !== 24'd10) begin mismatched++; $display("FAIL b2b_first: got v%b lane %0d idx %0d want v1 lane 0 idx 10", bus.res_valid, bus.res_lane, bus.res_idx); end
      compared++; if (lane_busy !== 8'h07) begin mismatched++; $display("FAIL b2b_busy: got %h want 07", lane_busy); end
      bus.res_ready = 1'b1;
      pulses = 0;
      @(negedge clk); pulses += int'(conv_done_partial);
      exp_d = 54;
      compared++; if (bus.res_valid !== 1'b1 || bus.res_lane !== 3'd1 || bus.res_data !== exp_d) begin mismatched++; $display("FAIL b2b_second: got lane %0d data %0d want lane 1 data 54", bus.res_lane, bus.res_data); end
      @(negedge clk); pulses += int'(conv_done_partial);
      exp_d = -36;
      compared++; if (bus.res_valid !== 1'b1 || bus.res_lane !== 3'd2 || bus.res_data !== exp_d || bus.res_idx !== 24'd12) begin mismatched++; $display("FAIL b2b_third: got lane %0d data %0d idx %0d want lane 2 data -36 idx 12", bus.res_lane, bus.res_data, bus.res_idx); end
      @(negedge clk); pulses += int'(conv_done_partial);
      compared++; if (bus.res_valid !== 1'b0 || conv_done_partial !== 1'b1) begin mismatched++; $display("FAIL b2b_drained: got valid %b partial %b want 0 1", bus.res_valid, conv_done_partial); end
      repeat (3) begin @(negedge clk); pulses += int'(conv_done_partial); end
      compared++; if (pulses != 1) begin mismatched++; $display("FAIL b2b_pulse_count: got %0d want 1", pulses); end
   endtask

   task automatic test_busy_lane;
      bit ok; int bad; bit seen;
      logic signed [ACCW-1:0] exp_d;
      bus.res_ready = 1'b0;
      drive_job(3, 20, 1'b0, mk(1, 0), mk(1, 0), ok);    // 9
      @(negedge clk);
      bus.job_valid = 1'b1; bus.job_lane = 3'd3; bus.job_idx = 24'd21;
      bus.job_img = mk(3, 0); bus.job_flt = mk(1, 0);      // 27
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         #1; if (bus.job_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      #1; if (bus.job_ready !== 1'b0) bad++;
      compared++; if (!ok || bad != 0) begin mismatched++; $display("FAIL busy_blocked: got accept %b ready-high cycles %0d want 1 0", ok, bad); end
      compared++; if (bus.res_valid !== 1'b1 || bus.res_lane !== 3'd3 || bus.res_data !== 52'sd9) begin mismatched++; $display("FAIL busy_first_result: got v%b lane %0d data %0d want v1 lane 3 data 9", bus.res_valid, bus.res_lane, bus.res_data); end
      bus.res_ready = 1'b1;
      @(negedge clk); #1;
      compared++; if (bus.job_ready !== 1'b1 || lane_busy[3] !== 1'b0 || conv_done_partial !== 1'b1) begin mismatched++; $display("FAIL busy_release: got ready %b busy %b partial %b want 1 0 1", bus.job_ready, lane_busy[3], conv_done_partial); end
      @(negedge clk);
      compared++; if (lane_busy[3] !== 1'b1) begin mismatched++; $display("FAIL busy_reaccept: got %b want 1", lane_busy[3]); end
      bus.job_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = bus.res_valid;
      end
      exp_d = 27;
      compared++; if (!seen || bus.res_data !== exp_d || bus.res_idx !== 24'd21) begin mismatched++; $display("FAIL busy_second_result: got v%b data %0d idx %0d want v1 data 27 idx 21", seen, bus.res_data, bus.res_idx); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_layer_end;
      bit ok; int nok, nres, pairbad, npart, nfull, last_drain, full_at, bad;
      bus.res_ready = 1'b1;
      nok = 0;
      for (int j = 0; j < 4; j++) begin
         drive_job(4 + j, 34 + j, (j == 3), mk(1, 0), mk(j + 1, 0), ok);
         nok += int'(ok);
      end
      nres = 0; pairbad = 0; npart = 0; nfull = 0; last_drain = -1; full_at = -2;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (conv_done_partial) npart++;
         if (conv_done_full) begin nfull++; full_at = n; end
         if (bus.res_valid && bus.res_ready) begin
            nres++; last_drain = n;
            if (bus.res_data !== ACCW'(9 * (int'(bus.res_lane) - 3)) ||
                bus.res_idx !== IDXW'(30 + int'(bus.res_lane))) pairbad++;
         end
      end
      compared++; if (nok != 4 || nres != 4) begin mismatched++; $display("FAIL last_counts: got accepts %0d results %0d want 4 4", nok, nres); end
      compared++; if (pairbad != 0) begin mismatched++; $display("FAIL last_pairing: got %0d bad pairs want 0", pairbad); end
      compared++; if (nfull != 1 || npart != 0) begin mismatched++; $display("FAIL last_pulses: got full %0d partial %0d want 1 0", nfull, npart); end
      compared++; if (full_at != last_drain + 1) begin mismatched++; $display("FAIL last_full_timing: got cycle %0d want %0d", full_at, last_drain + 1); end
      @(negedge clk);
      bus.job_valid = 1'b1; bus.job_lane = 3'd0; bus.job_last = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1; if (bus.job_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      bus.job_valid = 1'b0;
      compared++; if (bad != 0 || lane_busy !== '0) begin mismatched++; $display("FAIL last_blocks_jobs: got ready-high %0d busy %h want 0 00", bad, lane_busy); end
   endtask

   task automatic test_enable_abort;
      bit ok0, ok1, ok2, seen; int pulses;
      logic signed [ACCW-1:0] exp_d;
      @(negedge clk); en = 1'b0;
      @(negedge clk); en = 1'b1;
      #1;
      compared++; if (bus.job_ready !== 1'b1) begin mismatched++; $display("FAIL abort_reenable_ready: got %b want 1", bus.job_ready); end
      bus.res_ready = 1'b1;
      drive_job(0, 50, 1'b0, mk(1, 0), mk(1, 0), ok0);
      drive_job(1, 51, 1'b0, mk(2, 0), mk(2, 0), ok1);
      repeat (3) @(negedge clk);
      compared++; if (lane_busy !== 8'h03) begin mismatched++; $display("FAIL abort_running: got %h want 03", lane_busy); end
      en = 1'b0;
      @(negedge clk);
      compared++; if (lane_busy !== '0 || bus.res_valid !== 1'b0) begin mismatched++; $display("FAIL abort_cleared: got busy %h valid %b want 00 0", lane_busy, bus.res_valid); end
      pulses = int'(conv_done_partial) + int'(conv_done_full);
      repeat (2) begin @(negedge clk); pulses += int'(conv_done_partial) + int'(conv_done_full); end
      en = 1'b1;
      repeat (12) begin @(negedge clk); pulses += int'(conv_done_partial) + int'(conv_done_full) + int'(bus.res_valid); end
      compared++; if (pulses != 0 || !ok0 || !ok1) begin mismatched++; $display("FAIL abort_no_pulse: got %0d events want 0", pulses); end
      drive_job(2, 99, 1'b0, mk(-3, 0), mk(0, 1), ok2);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = bus.res_valid;
      end
      exp_d = -108;
      compared++; if (!ok2 || !seen || bus.res_data !== exp_d || bus.res_idx !== 24'd99 || bus.res_lane !== 3'd2) begin mismatched++; $display("FAIL abort_fresh_job: got data %0d idx %0d lane %0d want -108 99 2", bus.res_data, bus.res_idx, bus.res_lane); end
      @(negedge clk);
      compared++; if ({conv_done_partial, conv_done_full} !== 2'b10) begin mismatched++; $display("FAIL abort_fresh_done: got %b want 10", {conv_done_partial, conv_done_full}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_back_to_back();
      test_busy_lane();
      test_layer_end();
      test_enable_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
